game_mux: RTL and testbench

Parametrised successor to the fixed dice / traffic-light pair: one block containing an N-faced electronic dice, a traffic-light sequencer with programmable phase lengths, and a registered output selector. The selector has four modes: dice, lights, auto-alternate and freeze. It sits at the board top level and drives the LED/segment output bus directly.

---
 rtl/game_mux.sv | 184 ++++++++++++++++++
 tb/tb_game_mux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_mux.sv
// -----------------------------------------------------------------------------
// game_mux
//
// Board-level result selector combining an N-faced electronic dice, a
// free-running traffic-light sequencer with programmable phase lengths, and a
// registered output stage. The output stage can show the dice, the lights,
// alternate between them automatically, or freeze on its current value.
//
// Parameters:
//   WIDTH      result bus width (>= 3, 2^WIDTH-1 >= FACES)
//   FACES      number of dice faces, dice values run 1..FACES
//   RED_CYC    red phase length in clk cycles
//   RA_CYC     red+amber phase length in clk cycles
//   GREEN_CYC  green phase length in clk cycles
//   AMBER_CYC  amber phase length in clk cycles
//   SWAP       auto-mode dwell per source in clk cycles
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous, active-high reset
//   button  in   dice roll enable (level, sampled at clk edges)
//   mode    in   0 = dice, 1 = lights, 2 = auto-alternate, 3 = freeze
//   result  out  selected value, registered
//   src     out  source of result: 0 = dice, 1 = lights
// -----------------------------------------------------------------------------
module game_mux #(
    parameter int WIDTH     = 3,
    parameter int FACES     = 6,
    parameter int RED_CYC   = 2,
    parameter int RA_CYC    = 1,
    parameter int GREEN_CYC = 3,
    parameter int AMBER_CYC = 1,
    parameter int SWAP      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             button,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             src
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_DUR = max2(max2(RED_CYC, RA_CYC), max2(GREEN_CYC, AMBER_CYC));
    localparam int CNT_W   = $clog2(MAX_DUR) + 1;
    localparam int SC_W    = $clog2(SWAP) + 1;

    localparam logic [1:0] MODE_DICE   = 2'd0;
    localparam logic [1:0] MODE_LIGHTS = 2'd1;
    localparam logic [1:0] MODE_AUTO   = 2'd2;

    // Light encodings are {green, amber, red} so the state drives LEDs directly.
    typedef enum logic [2:0] {
        RED   = 3'b001,
        RA    = 3'b011,
        GREEN = 3'b100,
        AMBER = 3'b010
    } light_t;

    // -------------------------------------------------------------------------
    // Dice
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] throw_val;

    function automatic logic [WIDTH-1:0] next_throw(input logic [WIDTH-1:0] cur);
        if (cur >= WIDTH'(FACES))
            return WIDTH'(1);
        else
            return cur + WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            throw_val <= WIDTH'(1);
        else if (button)
            throw_val <= next_throw(throw_val);
    end

    // -------------------------------------------------------------------------
    // Traffic lights
    // -------------------------------------------------------------------------
    light_t           light;
    light_t           light_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last;
    logic [2:0]       light_bits;

    always_comb begin
        cnt_last   = CNT_W'(RED_CYC - 1);
        light_next = RA;
        case (light)
            RED: begin
                cnt_last   = CNT_W'(RED_CYC - 1);
                light_next = RA;
            end
            RA: begin
                cnt_last   = CNT_W'(RA_CYC - 1);
                light_next = GREEN;
            end
            GREEN: begin
                cnt_last   = CNT_W'(GREEN_CYC - 1);
                light_next = AMBER;
            end
            AMBER: begin
                cnt_last   = CNT_W'(AMBER_CYC - 1);
                light_next = RED;
            end
            default: begin
                cnt_last   = CNT_W'(0);
                light_next = RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light <= RED;
            cnt   <= '0;
        end else if (cnt >= cnt_last) begin
            light <= light_next;
            cnt   <= '0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign light_bits = light;

    // -------------------------------------------------------------------------
    // Auto-alternate source selection
    // -------------------------------------------------------------------------
    logic [SC_W-1:0] sc;
    logic            auto_src;

    // Outside auto mode the dwell is cleared so re-entry starts on the dice
    // with a full dwell; this clear also overrides a coincident toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sc       <= '0;
            auto_src <= 1'b0;
        end else if (mode != MODE_AUTO) begin
            sc       <= '0;
            auto_src <= 1'b0;
        end else if (sc >= SC_W'(SWAP - 1)) begin
            sc       <= '0;
            auto_src <= ~auto_src;
        end else begin
            sc       <= sc + SC_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output register (freeze simply leaves it untouched)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            src    <= 1'b0;
        end else begin
            case (mode)
                MODE_DICE: begin
                    result <= throw_val;
                    src    <= 1'b0;
                end
                MODE_LIGHTS: begin
                    result <= WIDTH'(light_bits);
                    src    <= 1'b1;
                end
                MODE_AUTO: begin
                    result <= auto_src ? WIDTH'(light_bits) : throw_val;
                    src    <= auto_src;
                end
                default: begin
                    result <= result;
                    src    <= src;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_mux.sv
// -----------------------------------------------------------------------------
// tb_game_mux
//
// Directed self-checking bench for game_mux with default parameters
// (WIDTH=3, FACES=6, phases 2/1/3/1, SWAP=4). Inputs change 1 time unit
// after the rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_game_mux;

    localparam int WIDTH = 3;

    logic             clk;
    logic             clk_en;
    logic             rst;
    logic             button;
    logic [1:0]       mode;
    logic [WIDTH-1:0] result;
    logic             src;

    int checks;
    int errors;

    game_mux #(
        .WIDTH    (3),
        .FACES    (6),
        .RED_CYC  (2),
        .RA_CYC   (1),
        .GREEN_CYC(3),
        .AMBER_CYC(1),
        .SWAP     (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .button(button),
        .mode  (mode),
        .result(result),
        .src   (src)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    int exp_dice[8];
    int exp_auto_res[13];
    int exp_auto_src[13];
    int exp_lights[8];

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b1;
        rst    = 1'b1;
        button = 1'b0;
        mode   = 2'd0;

        exp_dice     = '{1, 2, 3, 4, 5, 6, 1, 2};
        exp_lights   = '{1, 1, 3, 4, 4, 4, 2, 1};
        exp_auto_res = '{1, 1, 1, 1, 4, 4, 2, 1, 1, 1, 1, 1, 4};
        exp_auto_src = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1};

        // Reset held with clock running
        tick();
        tick();
        chk("rst_result", 32'(result), 0);
        chk("rst_src", 32'(src), 0);

        // First lights outputs, then asynchronous reset with clock stopped
        mode = 2'd1;
        rst  = 1'b0;
        tick();
        chk("first_lights", 32'(result), 1);
        chk("first_lights_src", 32'(src), 1);
        tick();
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        rst = 1'b1;
        #1;
        chk("async_rst_result", 32'(result), 0);
        chk("async_rst_src", 32'(src), 0);
        #5;
        rst    = 1'b0;
        clk_en = 1'b1;

        // Dice wrap
        mode   = 2'd0;
        button = 1'b1;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("dice_e%0d", k + 1), 32'(result), 32'(exp_dice[k]));
            chk("dice_src", 32'(src), 0);
        end
        button = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("dice_hold%0d", k), 32'(result), 3);
        end

        // Lights sequence
        mode = 2'd1;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            chk($sformatf("lights_e%0d", k + 1), 32'(result), 32'(exp_lights[k]));
            chk("lights_src", 32'(src), 1);
        end

        // Auto alternate
        mode = 2'd2;
        apply_reset();
        for (int k = 0; k < 13; k++) begin
            tick();
            chk($sformatf("auto_res_e%0d", k + 1), 32'(result), 32'(exp_auto_res[k]));
            chk($sformatf("auto_src_e%0d", k + 1), 32'(src), 32'(exp_auto_src[k]));
        end
        mode = 2'd1;
        tick();
        chk("auto_leave_res", 32'(result), 2);
        chk("auto_leave_src", 32'(src), 1);
        mode = 2'd2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("auto_reenter_src%0d", k), 32'(src), 0);
            chk($sformatf("auto_reenter_res%0d", k), 32'(result), 1);
        end
        tick();
        chk("auto_reenter_swap_src", 32'(src), 1);
        chk("auto_reenter_swap_res", 32'(result), 4);

        // Freeze
        mode   = 2'd1;
        button = 1'b0;
        apply_reset();
        for (int k = 0; k < 4; k++) tick();
        chk("freeze_pre", 32'(result), 4);
        mode   = 2'd3;
        button = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("freeze_res%0d", k), 32'(result), 4);
            chk($sformatf("freeze_src%0d", k), 32'(src), 1);
        end
        mode   = 2'd0;
        button = 1'b0;
        tick();
        chk("freeze_exit_res", 32'(result), 5);
        chk("freeze_exit_src", 32'(src), 0);

        // Reset mid-run during GREEN with throw=5 in auto mode
        mode   = 2'd0;
        button = 1'b1;
        apply_reset();
        for (int k = 0; k < 4; k++) tick();
        chk("mid_pre_dice", 32'(result), 4);
        button = 1'b0;
        mode   = 2'd2;
        tick();
        chk("mid_pre_throw5", 32'(result), 5);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_result", 32'(result), 0);
        chk("mid_rst_src", 32'(src), 0);
        #1;
        rst = 1'b0;
        tick();
        chk("mid_resume_throw", 32'(result), 1);
        chk("mid_resume_src", 32'(src), 0);
        mode = 2'd1;
        tick();
        chk("mid_resume_red", 32'(result), 1);
        tick();
        chk("mid_resume_ra", 32'(result), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
